// File: rtl/core_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_config_pkg
// Description : Shared core configuration: data width, memory-map defaults,
//               responder FSM/region encodings and small datapath helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package core_config_pkg;

    localparam int XLEN = 32;

    // Default memory map. RAM overlaps the top half of the ROM window; the
    // decoder resolves the overlap in favour of RAM.
    localparam logic [XLEN-1:0] c_ram_base    = 32'h0002_0000;
    localparam logic [XLEN-1:0] c_rom_base    = 32'h0000_0000;
    localparam logic [XLEN-1:0] c_mmio_base   = 32'h1000_0000;
    localparam int              c_ram_words   = 32768;
    localparam int              c_rom_words   = 65536;
    localparam int              c_mmio_words  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_MMIO_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_ROM      = 2'd1,
        REG_MMIO     = 2'd2,
        REG_UNMAPPED = 2'd3
    } region_e;

    // True when addr lies in [base, base + 4*words); 33-bit math avoids wrap.
    function automatic logic in_window(input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] base,
                                       input int              words);
        logic [XLEN:0] span;
        logic [XLEN:0] off;
        span = (XLEN+1)'(words) << 2;
        off  = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span);
    endfunction

    // Zero every byte lane whose enable bit is clear.
    function automatic logic [XLEN-1:0] mask_lanes(input logic [XLEN-1:0]   data,
                                                   input logic [XLEN/8-1:0] be);
        logic [XLEN-1:0] m;
        m = '0;
        for (int i = 0; i < XLEN/8; i++) begin
            m[8*i +: 8] = be[i] ? data[8*i +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_decode
// Description : Combinational address decoder: byte address -> target region
//               plus word-misalignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_decode
    import core_config_pkg::*;
#(
    parameter logic [XLEN-1:0] RAM_BASE   = c_ram_base,
    parameter logic [XLEN-1:0] ROM_BASE   = c_rom_base,
    parameter logic [XLEN-1:0] MMIO_BASE  = c_mmio_base,
    parameter int              RAM_WORDS  = c_ram_words,
    parameter int              ROM_WORDS  = c_rom_words,
    parameter int              MMIO_WORDS = c_mmio_words
) (
    input  logic [XLEN-1:0] addr,
    output region_e         region,
    output logic            misaligned
);

    // Priority RAM > ROM > MMIO so the RAM window shadows overlapping ROM.
    always_comb begin
        region     = REG_UNMAPPED;
        misaligned = (addr[1:0] != 2'b00);
        if (in_window(addr, RAM_BASE, RAM_WORDS)) begin
            region = REG_RAM;
        end else if (in_window(addr, ROM_BASE, ROM_WORDS)) begin
            region = REG_ROM;
        end else if (in_window(addr, MMIO_BASE, MMIO_WORDS)) begin
            region = REG_MMIO;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding core memory responder routing requests to
//               RAM, ROM or MMIO with error detection and MMIO timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import core_config_pkg::*;
#(
    parameter logic [XLEN-1:0] RAM_BASE     = c_ram_base,
    parameter logic [XLEN-1:0] ROM_BASE     = c_rom_base,
    parameter logic [XLEN-1:0] MMIO_BASE    = c_mmio_base,
    parameter int              RAM_WORDS    = c_ram_words,
    parameter int              ROM_WORDS    = c_rom_words,
    parameter int              MMIO_WORDS   = c_mmio_words,
    parameter int              MEM_LAT      = 1,
    parameter int              MMIO_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN/8-1:0] mem_byteen,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              mem_busy,
    output logic              mem_rvalid,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_err,
    output logic [14:0]       ram_addr,
    output logic              ram_we,
    output logic [XLEN/8-1:0] ram_byteen,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic [XLEN-1:0]   ram_q,
    output logic [15:0]       rom_addr,
    output logic              rom_rden,
    input  logic [XLEN-1:0]   rom_q,
    output logic              mmio_sel,
    output logic              mmio_we,
    output logic [9:0]        mmio_addr,
    output logic [XLEN/8-1:0] mmio_byteen,
    output logic [XLEN-1:0]   mmio_wdata,
    input  logic [XLEN-1:0]   mmio_rdata,
    input  logic              mmio_ack
);

    localparam int            c_tmo_w    = $clog2(MMIO_TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(MMIO_TIMEOUT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max  = c_tmo_w'(MMIO_TIMEOUT);
    localparam logic [1:0]    c_lat_last = 2'(MEM_LAT - 1);

    state_e              r_state, w_state_nxt;
    region_e             w_dec_region;
    logic                w_dec_misaligned;
    logic                w_req_err;
    logic                w_accept;
    logic                w_mmio_tmo;
    region_e             r_region;
    logic                r_we;
    logic                r_err;
    logic [XLEN/8-1:0]   r_byteen;
    logic [XLEN-1:0]     r_data;
    logic [1:0]          r_lat_cnt;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic [XLEN-1:0]     w_src;

    mem_addr_decode #(
        .RAM_BASE   (RAM_BASE),
        .ROM_BASE   (ROM_BASE),
        .MMIO_BASE  (MMIO_BASE),
        .RAM_WORDS  (RAM_WORDS),
        .ROM_WORDS  (ROM_WORDS),
        .MMIO_WORDS (MMIO_WORDS)
    ) u_decode (
        .addr       (mem_addr),
        .region     (w_dec_region),
        .misaligned (w_dec_misaligned)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: accept/route in IDLE, wait for memory or MMIO, respond.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mmio_tmo  = 1'b0;
        w_req_err   = (w_dec_region == REG_UNMAPPED) || w_dec_misaligned ||
                      (mem_byteen == '0) || (mem_we && (w_dec_region == REG_ROM));
        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_accept = 1'b1;
                    if (w_req_err || ((w_dec_region == REG_RAM) && mem_we))
                        w_state_nxt = ST_RESP;
                    else if (w_dec_region == REG_MMIO)
                        w_state_nxt = ST_MMIO_WAIT;
                    else
                        w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (r_lat_cnt == c_lat_last) w_state_nxt = ST_RESP;
            end
            ST_MMIO_WAIT: begin
                // Ack wins over a simultaneous timeout expiry.
                if (mmio_ack) begin
                    w_state_nxt = ST_RESP;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_state_nxt = ST_RESP;
                    w_mmio_tmo  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory read data is valid in RESP, MEM_LAT cycles after the address.
    always_comb begin
        w_src = r_data;
        case (r_region)
            REG_RAM: w_src = ram_q;
            REG_ROM: w_src = rom_q;
            default: w_src = r_data;
        endcase
    end

    // Registered request context, downstream strobes and core response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_region    <= REG_UNMAPPED;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_byteen    <= '0;
            r_data      <= '0;
            r_lat_cnt   <= '0;
            r_tmo_cnt   <= '0;
            mem_busy    <= 1'b0;
            mem_rvalid  <= 1'b0;
            mem_rdata   <= '0;
            mem_err     <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_byteen  <= '0;
            ram_wdata   <= '0;
            rom_addr    <= '0;
            rom_rden    <= 1'b0;
            mmio_sel    <= 1'b0;
            mmio_we     <= 1'b0;
            mmio_addr   <= '0;
            mmio_byteen <= '0;
            mmio_wdata  <= '0;
        end else begin
            mem_rvalid <= 1'b0;
            ram_we     <= 1'b0;
            if (w_accept) begin
                mem_busy  <= 1'b1;
                r_region  <= w_dec_region;
                r_we      <= mem_we;
                r_err     <= w_req_err;
                r_byteen  <= mem_byteen;
                r_lat_cnt <= '0;
                r_tmo_cnt <= '0;
                if (!w_req_err) begin
                    case (w_dec_region)
                        REG_RAM: begin
                            ram_addr   <= 15'((mem_addr - RAM_BASE) >> 2);
                            ram_we     <= mem_we;
                            ram_byteen <= mem_byteen;
                            ram_wdata  <= mem_wdata;
                        end
                        REG_ROM: begin
                            rom_addr <= 16'((mem_addr - ROM_BASE) >> 2);
                            rom_rden <= 1'b1;
                        end
                        REG_MMIO: begin
                            mmio_sel    <= 1'b1;
                            mmio_we     <= mem_we;
                            mmio_addr   <= 10'((mem_addr - MMIO_BASE) >> 2);
                            mmio_byteen <= mem_byteen;
                            mmio_wdata  <= mem_wdata;
                        end
                        default: ;
                    endcase
                end
            end
            case (r_state)
                ST_MEM_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 2'd1;
                    if (w_state_nxt == ST_RESP) rom_rden <= 1'b0;
                end
                ST_MMIO_WAIT: begin
                    if (r_tmo_cnt != c_tmo_max) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (mmio_ack) begin
                        r_data   <= mmio_rdata;
                        mmio_sel <= 1'b0;
                    end else if (w_mmio_tmo) begin
                        r_err    <= 1'b1;
                        mmio_sel <= 1'b0;
                    end
                end
                ST_RESP: begin
                    mem_rvalid <= 1'b1;
                    mem_busy   <= 1'b0;
                    mem_err    <= r_err;
                    mem_rdata  <= (r_err || r_we) ? '0 : mask_lanes(w_src, r_byteen);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
